// File: rtl/lrpt_pkg.sv
// Shared LRPT frame constants, aligner state
// and QPSK derotation helper.
package lrpt_pkg;

  localparam int BITS_PER_FRAME = 80;
  localparam int NUM_FRAMES     = 32;
  localparam int UW_BITS        = 8;

  localparam logic [7:0] SYNC_WORD = 8'h27;

  typedef enum logic [1:0] {
    LOAD,
    WAIT_SYNC,
    EMIT
  } aligner_state_t;

  typedef struct packed {
    logic [1:0] data;
    logic       frame_start;
    logic       last;
  } out_pair_t;

  function automatic logic [1:0] derotate_pair(
    input logic       i,
    input logic       q,
    input logic [1:0] rot
  );
    logic [1:0] r;
    unique case (rot)
      2'd0:    r = {i, q};
      2'd1:    r = {q, ~i};
      2'd2:    r = {~i, ~q};
      default: r = {~q, i};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// True dual-port read-first block RAM with
// output registers (2-cycle read latency).
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int RAM_WIDTH = 1,
  parameter int RAM_DEPTH = 2560,
  parameter int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 clkb,
  input  logic                 ena,
  input  logic                 enb,
  input  logic                 wea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [ADDR_W-1:0]    addrb,
  input  logic [RAM_WIDTH-1:0] dina,
  output logic [RAM_WIDTH-1:0] douta,
  output logic [RAM_WIDTH-1:0] doutb
);

  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_a;
  logic [RAM_WIDTH-1:0] ram_b;

  // port A: write plus read-first array read
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) ram[addra] <= dina;
      ram_a <= ram[addra];
    end
  end

  // port A output register
  always_ff @(posedge clka) begin
    douta <= ram_a;
  end

  // port B: array read
  always_ff @(posedge clkb) begin
    if (enb) ram_b <= ram[addrb];
  end

  // port B output register
  always_ff @(posedge clkb) begin
    doutb <= ram_b;
  end

endmodule

// File: rtl/uw_frame_aligner.sv
// Buffers one block of hard bits, then streams
// derotated, UW-stripped payload pairs.
module uw_frame_aligner
  import lrpt_pkg::*;
#(
  parameter int BITS_PER_FRAME = lrpt_pkg::BITS_PER_FRAME,
  parameter int NUM_FRAMES     = lrpt_pkg::NUM_FRAMES,
  parameter int UW_BITS        = lrpt_pkg::UW_BITS,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_in,
  input  logic                              hard_inp,
  input  logic                              valid_in,
  output logic                              ready_rx,
  input  logic                              sync_valid_in,
  input  logic [$clog2(BITS_PER_FRAME)-1:0] sync_offset_in,
  input  logic [3:0]                        sync_rotation_in,
  output logic [1:0]                        data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              frame_start_out,
  output logic                              block_done_out
);

  localparam int N     = NUM_FRAMES * BITS_PER_FRAME;
  localparam int AW    = $clog2(N);
  localparam int OW    = $clog2(BITS_PER_FRAME);
  localparam int PAIRS = (BITS_PER_FRAME - UW_BITS) / 2;
  localparam int PW    = $clog2(PAIRS);
  localparam int FW    = $clog2(NUM_FRAMES + 1);
  localparam int QW    = $clog2(OUT_FIFO_DEPTH);
  localparam int CW    = QW + 1;

  localparam logic [AW-1:0] LAST_WR    = AW'(N - 1);
  localparam logic [AW-1:0] PAIR_STEP  = AW'(2);
  localparam logic [AW-1:0] FRAME_STEP = AW'(UW_BITS + 2);
  localparam logic [AW-1:0] UW_SKIP    = AW'(UW_BITS);
  localparam logic [PW-1:0] PAIR_LAST  = PW'(PAIRS - 1);
  localparam logic [FW-1:0] FR_FULL    = FW'(NUM_FRAMES);
  localparam logic [FW-1:0] FR_PART    = FW'(NUM_FRAMES - 1);
  localparam logic [CW:0]   DEPTH_W    = (CW+1)'(OUT_FIFO_DEPTH);

  aligner_state_t state, state_nx;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic          sync_hit;
  logic [OW-1:0] off_q;
  logic [1:0]    rot_q;
  logic [PW-1:0] pair_idx;
  logic [FW-1:0] frame_idx;
  logic [FW-1:0] frames_total;
  logic          issue_done;
  logic          wr_en;
  logic          issue;
  logic          last_issue;
  logic          v1, v2, fs1, fs2, lt1, lt2;
  logic          dout_a, dout_b;
  logic          push, pop, blk_end;
  logic          unused_rot;

  out_pair_t     fifo [OUT_FIFO_DEPTH];
  out_pair_t     head;
  out_pair_t     push_entry;
  logic [QW-1:0] fifo_wp, fifo_rp;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   occupancy;

  assign unused_rot = ^sync_rotation_in[3:2];

  assign head       = fifo[fifo_rp];
  assign valid_out  = fifo_cnt != '0;
  assign data_out   = valid_out ? head.data : 2'b00;
  assign frame_start_out = valid_out & head.frame_start;
  assign pop        = valid_out & ready_in;
  assign blk_end    = pop & head.last;
  assign push       = v2;
  assign occupancy  = {1'b0, fifo_cnt}
                    + (CW+1)'(v1) + (CW+1)'(v2);

  assign last_issue = issue
                    && (pair_idx == PAIR_LAST)
                    && (frame_idx == frames_total - 1'b1);

  assign addr_a = (state == LOAD) ? wr_ptr : rd_addr;
  assign addr_b = rd_addr + 1'b1;

  assign push_entry = '{
    data:        derotate_pair(dout_a, dout_b, rot_q),
    frame_start: fs2,
    last:        lt2
  };

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH (1),
    .RAM_DEPTH (N),
    .ADDR_W    (AW)
  ) u_ram (
    .clka  (clk),
    .clkb  (clk),
    .ena   (1'b1),
    .enb   (1'b1),
    .wea   (wr_en),
    .addra (addr_a),
    .addrb (addr_b),
    .dina  (hard_inp),
    .douta (dout_a),
    .doutb (dout_b)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst_in) state <= LOAD;
    else        state <= state_nx;
  end

  // next state, load handshake and read issue
  always_comb begin
    state_nx = state;
    ready_rx = 1'b0;
    wr_en    = 1'b0;
    issue    = 1'b0;
    unique case (state)
      LOAD: begin
        ready_rx = 1'b1;
        wr_en    = valid_in;
        if (valid_in && wr_ptr == LAST_WR)
          state_nx = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        if (sync_hit) state_nx = EMIT;
      end
      EMIT: begin
        issue = !issue_done
             && (occupancy < DEPTH_W);
        if (blk_end) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // write pointer and sync latch
  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      sync_hit <= 1'b0;
      off_q    <= '0;
      rot_q    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (blk_end) begin
        wr_ptr   <= '0;
        sync_hit <= 1'b0;
      end else if (sync_valid_in && state != EMIT) begin
        sync_hit <= 1'b1;
        off_q    <= sync_offset_in;
        rot_q    <= sync_rotation_in[1:0];
      end
    end
  end

  // read address accumulator over frames and pairs
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_addr      <= '0;
      pair_idx     <= '0;
      frame_idx    <= '0;
      frames_total <= '0;
      issue_done   <= 1'b0;
    end else if (state != EMIT) begin
      rd_addr      <= AW'(off_q) + UW_SKIP;
      pair_idx     <= '0;
      frame_idx    <= '0;
      issue_done   <= 1'b0;
      frames_total <= (off_q == '0) ? FR_FULL : FR_PART;
    end else if (issue) begin
      if (pair_idx == PAIR_LAST) begin
        pair_idx  <= '0;
        frame_idx <= frame_idx + 1'b1;
        rd_addr   <= rd_addr + FRAME_STEP;
        if (last_issue) issue_done <= 1'b1;
      end else begin
        pair_idx <= pair_idx + 1'b1;
        rd_addr  <= rd_addr + PAIR_STEP;
      end
    end
  end

  // tags riding alongside the RAM read latency
  always_ff @(posedge clk) begin
    if (rst_in) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      fs1 <= 1'b0;
      fs2 <= 1'b0;
      lt1 <= 1'b0;
      lt2 <= 1'b0;
    end else begin
      v1  <= issue;
      fs1 <= issue && (pair_idx == '0);
      lt1 <= last_issue;
      v2  <= v1;
      fs2 <= fs1;
      lt2 <= lt1;
    end
  end

  // skid FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo[fifo_wp] <= push_entry;
  end

  // skid FIFO pointers, occupancy, block-done pulse
  always_ff @(posedge clk) begin
    if (rst_in) begin
      fifo_wp        <= '0;
      fifo_rp        <= '0;
      fifo_cnt       <= '0;
      block_done_out <= 1'b0;
    end else begin
      block_done_out <= blk_end;
      if (push) fifo_wp <= fifo_wp + 1'b1;
      if (pop)  fifo_rp <= fifo_rp + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: doc/uw_frame_aligner.md
Name: uw_frame_aligner

Overview:
Sits directly downstream of the unique-word correlator stage. Buffers one block of NUM_FRAMES x BITS_PER_FRAME hard bits while the correlator scores it. It then takes the winning bit offset and QPSK rotation, derotates each I/Q bit pair and strips the 8-bit unique word from every frame. It streams aligned payload symbol pairs to the deinterleaver/Viterbi stage with backpressure.

Parameters:
BITS_PER_FRAME, 80, hard bits per frame including UW
NUM_FRAMES, 32, frames per block (must match correlator)
UW_BITS, 8, unique-word bits stripped at frame start
OUT_FIFO_DEPTH, 4, output skid entries; power of 2, >= read latency + 2

Ports:
clk  in  1  system clock
rst_in  in  1  synchronous active-high reset
hard_inp  in  1  hard-decision bit, I/Q interleaved (even bit = I, odd bit = Q)
valid_in  in  1  hard_inp qualifier; only honoured while ready_rx=1
ready_rx  out  1  high while in LOAD and able to accept bits
sync_valid_in  in  1  one-cycle strobe from correlator
sync_offset_in  in  $clog2(BITS_PER_FRAME)  UW start offset within frame
sync_rotation_in  in  4  QPSK rotation; only [1:0] used
data_out  out  2  {I,Q} derotated payload pair
valid_out  out  1  data_out valid
ready_in  in  1  downstream accept; transfer when valid_out && ready_in
frame_start_out  out  1  high with first pair of each frame
block_done_out  out  1  one-cycle pulse after last pair of block accepted

Behaviour:
- Reset: state=LOAD, write pointer=0, sync latch cleared, FIFO empty. Outputs: ready_rx=1, valid_out=0, data_out=0, frame_start_out=0, block_done_out=0.
- Storage: 1-bit-wide true dual-port BRAM, depth N=NUM_FRAMES*BITS_PER_FRAME, 2-cycle read latency.
- LOAD:
  - Each cycle with valid_in=1 writes hard_inp at wr_ptr, then increments wr_ptr.
  - After write N-1, ready_rx goes low the next cycle and the state moves to WAIT_SYNC.
  - Gaps in valid_in are allowed; no bit is dropped.
- Sync latch: sync_valid_in is captured in any state except EMIT, including during LOAD. The latest strobe wins. sync_valid_in in EMIT is ignored.
- WAIT_SYNC: on a latched sync, move to EMIT. A sync latched during LOAD moves the block to EMIT one cycle after LOAD completes.
- EMIT addressing:
  - Frames to emit: F = NUM_FRAMES if offset==0, otherwise NUM_FRAMES-1. A partial last frame is discarded.
  - For frame f = 0..F-1 and pair p = 0..(BITS_PER_FRAME-UW_BITS)/2-1:
    - Port A reads base = offset + f*BITS_PER_FRAME + UW_BITS + 2p.
    - Port B reads base+1.
  - The address is an accumulator; no multiplier.
- Derotation, with I=bit[base] and Q=bit[base+1]:
  - rot0: (I,Q)
  - rot1: (Q,~I)
  - rot2: (~I,~Q)
  - rot3: (~Q,I)
- Flow control:
  - A read issues only when FIFO occupancy + reads in flight < OUT_FIFO_DEPTH.
  - A stalled ready_in never loses or duplicates a pair.
  - valid_out is driven from a non-empty FIFO.
- frame_start_out travels with its pair through the FIFO.
- Block end: when the final pair is accepted, block_done_out pulses for 1 cycle. wr_ptr and the sync latch clear, and the state returns to LOAD, so ready_rx=1 on the next cycle.
- Latency: first valid_out is 3 cycles after entering EMIT (2 RAM + 1 FIFO).
- Throughput: 1 pair/cycle with ready_in held high.
- Reset mid-operation: everything is abandoned next cycle and reset values apply; RAM contents are don't-care.
- Boundaries:
  - offset = BITS_PER_FRAME-1 gives the highest address, (NUM_FRAMES-2)*BITS_PER_FRAME + 2*BITS_PER_FRAME-2 < N, so it stays in range.
  - sync_rotation_in[3:2] are ignored.
  - valid_in while ready_rx=0 is ignored.

Decomposition:
- Shared package lrpt_pkg holds:
  - the default frame constants BITS_PER_FRAME, NUM_FRAMES and UW_BITS;
  - the sync-word constant;
  - the aligner state typedef {LOAD, WAIT_SYNC, EMIT};
  - a derotate_pair function taking (I,Q,rot).
- One natural sub-module: existing xilinx_true_dual_port_read_first_2_clock_ram used for storage.
- The output skid FIFO stays inline.

Test Plan:
- Block with UW 0x27 at offset 0, rot 0, ready_in=1, payload bits ramping -> 32 frames x 36 pairs = 1152 transfers matching stored pairs; frame_start_out on transfers 0, 36, 72, ...; block_done_out once.
- Same data shifted to offset 37, sync rot 2 -> 31 frames, every pair bit-inverted relative to rot0 golden, first pair = bits 45/46.
- rot1 and rot3 with known I=1,Q=0 payload -> data_out = {0,0} for rot1 and {1,1} for rot3 on every pair.
- ready_in toggled pseudo-randomly at 50% during EMIT -> identical sequence to the full-rate run, no drops or duplicates, valid_out stable while stalled.
- sync_valid_in pulsed during LOAD at bit 2000 (offset 5), valid_in gapped -> EMIT starts exactly one cycle after bit 2559; first read uses offset 5.
- rst_in asserted mid-EMIT at pair 500 -> next cycle valid_out=0, ready_rx=1; a subsequent clean block emits correctly.
